pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain_if.sv | 31 +++
 rtl/pipe_stage_chain.sv | 111 +++++++++++
 tb/tb_pipe_stage_chain.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream offer/accept and downstream valid/consume.
interface pipe_stage_chain_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: produces input payloads and consumes outputs
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Pipeline side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/ready register stages with bubble collapse, flush and occupancy count.
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_chain_if.slave   bus,
    output logic [DEPTH-1:0]    stage_valid,
    output logic [CNT_W-1:0]    occupancy
);

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_d;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_d;

    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  down_rdy;
    logic [DEPTH-1:0]  up_vld;
    logic [DATA_W-1:0] up_data [DEPTH];
    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  drain;
    logic [DEPTH-1:0]  empty;

    // A stage can accept when downstream consumes or any stage at or after it is empty;
    // written in closed form so the ready chain has no bit-to-bit feedback in one vector.
    always_comb begin
        empty = ~v_q;
        rdy   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rdy[i] = bus.out_ready | (|(empty >> i));
        end
    end

    // Neighbour views: what feeds each stage and what each stage drains into
    always_comb begin
        up_vld     = '0;
        up_data[0] = bus.in_data;
        up_vld[0]  = bus.in_valid;
        for (int i = 1; i < int'(DEPTH); i++) begin
            up_vld[i]  = v_q[i-1];
            up_data[i] = d_q[i-1];
        end
        down_rdy          = '0;
        down_rdy[DEPTH-1] = bus.out_ready;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            down_rdy[i] = rdy[i+1];
        end
    end

    // Per-stage load / drain / hold; flush kills everything including this cycle's offer
    always_comb begin
        v_d   = v_q;
        load  = '0;
        drain = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_d[i]   = d_q[i];
            load[i]  = up_vld[i] & rdy[i];
            drain[i] = v_q[i] & down_rdy[i];
            if (load[i]) begin
                v_d[i] = 1'b1;
                d_d[i] = up_data[i];
            end else if (drain[i]) begin
                v_d[i] = 1'b0;
                d_d[i] = '0;
            end
        end
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_d[i] = '0;
            end
        end
    end

    // Occupancy is registered alongside the valid bits it counts
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + CNT_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = d_q[DEPTH-1];
    assign stage_valid   = v_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain with DATA_W=32, DEPTH=3.
module tb_pipe_stage_chain;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [DEPTH-1:0] stage_valid;
    logic [CNT_W-1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_chain_if #(.DATA_W(DATA_W)) bus ();

    pipe_stage_chain #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .stage_valid(stage_valid),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] data, input logic ordy);
        bus.in_valid  = vld;
        bus.in_data   = data;
        bus.out_ready = ordy;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  bus.out_data,       32'h0);
        check("rst_stage_vld", 32'(stage_valid),   32'h0);
        check("rst_occupancy", 32'(occupancy),     32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);

        // Streaming: 0x11 handshakes before edge 1 and is on out_data after edge 3
        drive(1'b1, 32'h11, 1'b1);
        check("str_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b1, 32'h22, 1'b1);
        check("str_e1_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        drive(1'b1, 32'h33, 1'b1);
        check("str_e2_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        check("str_e3_out_data", bus.out_data,     32'h11);
        check("str_e3_occ",      32'(occupancy),   32'h3);
        tick();
        check("str_e4_out_data", bus.out_data,     32'h22);
        check("str_e4_occ",      32'(occupancy),   32'h2);
        tick();
        check("str_e5_out_data", bus.out_data,     32'h33);
        check("str_e5_occ",      32'(occupancy),   32'h1);
        tick();
        check("str_e6_out_valid", 32'(bus.out_valid), 32'h0);
        check("str_e6_occ",       32'(occupancy),     32'h0);

        // Fill and stall with out_ready low
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hA0 + 32'(k), 1'b0);
            tick();
        end
        drive(1'b1, 32'hA3, 1'b0);
        check("fill_in_ready",  32'(bus.in_ready), 32'h0);
        check("fill_stage_vld", 32'(stage_valid),  32'h7);
        check("fill_occ",       32'(occupancy),    32'h3);
        check("fill_out_data",  bus.out_data,      32'hA0);
        tick();
        check("stall_stage_vld", 32'(stage_valid), 32'h7);
        check("stall_out_data",  bus.out_data,     32'hA0);

        // Full pass-through: 0xA0 leaves while 0xB0 enters
        drive(1'b1, 32'hB0, 1'b1);
        check("pass_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        check("pass_out_data", bus.out_data,    32'hA1);
        check("pass_occ",      32'(occupancy),  32'h3);

        // Build a 3'b101 pattern, then collapse the bubble under back-pressure
        tick();
        check("bub_a_stage_vld", 32'(stage_valid), 32'h6);
        check("bub_a_out_data",  bus.out_data,     32'hA2);
        drive(1'b1, 32'hC1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        check("bub_b_stage_vld", 32'(stage_valid), 32'h5);
        check("bub_b_out_data",  bus.out_data,     32'hB0);
        check("bub_b_occ",       32'(occupancy),   32'h2);
        tick();
        check("bub_c_stage_vld", 32'(stage_valid), 32'h6);
        check("bub_c_out_data",  bus.out_data,     32'hB0);
        check("bub_c_occ",       32'(occupancy),   32'h2);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        check("bub_d_out_data", bus.out_data,   32'hC1);
        check("bub_d_occ",      32'(occupancy), 32'h1);
        tick();
        check("bub_e_out_valid", 32'(bus.out_valid), 32'h0);

        // Flush a full chain while 0xCC is offered
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hD0 + 32'(k), 1'b0);
            tick();
        end
        check("fl_pre_stage_vld", 32'(stage_valid), 32'h7);
        flush = 1'b1;
        drive(1'b1, 32'hCC, 1'b1);
        check("fl_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        check("fl_stage_vld", 32'(stage_valid),   32'h0);
        check("fl_out_valid", 32'(bus.out_valid), 32'h0);
        check("fl_out_data",  bus.out_data,       32'h0);
        check("fl_occ",       32'(occupancy),     32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fl_no_emerge", 32'(bus.out_valid), 32'h0);
        end

        // Reset wins over flush mid-stream
        drive(1'b1, 32'hE0, 1'b1);
        tick();
        drive(1'b1, 32'hE1, 1'b1);
        tick();
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'hEE, 1'b1);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        check("rf_out_valid", 32'(bus.out_valid), 32'h0);
        check("rf_out_data",  bus.out_data,       32'h0);
        check("rf_stage_vld", 32'(stage_valid),   32'h0);
        check("rf_occ",       32'(occupancy),     32'h0);
        check("rf_in_ready",  32'(bus.in_ready),  32'h1);
        drive(1'b1, 32'h55, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        check("rf_e1_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("rf_e2_out_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("rf_e3_out_valid", 32'(bus.out_valid), 32'h1);
        check("rf_e3_out_data",  bus.out_data,       32'h55);
        tick();
        check("rf_e4_out_valid", 32'(bus.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
